stack_unit: RTL and testbench
=============================

# stack_unit

Hardware operand stack for the multicycle stack CPU. It is the datapath stage driven directly by the controller's `tos`, `pop`, `push` and `MtoS` strobes. It sits between the memory data register / ALU result and the A/B operand registers and the memory address mux. It holds up to DEPTH words, presents a registered top-of-stack/popped word on `d_out`, and flags overflow and underflow.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, maximum number of entries; must be a power of two ≥ 2.
- SPW, $clog2(DEPTH)+1, stack-pointer width; holds 0..DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tos  input  1  read the top entry into `d_out` without removing it.
- pop  input  1  remove the top entry and place it in `d_out`.
- push  input  1  write the selected input word as the new top.
- MtoS  input  1  push source select: 1 = `mem_data`, 0 = `alu_res`.
- mem_data  input  WIDTH  word read from memory.
- alu_res  input  WIDTH  ALU result.
- clr_err  input  1  synchronous clear of the sticky error flags.
- d_out  output  WIDTH  registered word from the last successful `tos`/`pop`.
- sp  output  SPW  current entry count.
- empty  output  1  `sp == 0`, combinational from `sp`.
- full  output  1  `sp == DEPTH`, combinational from `sp`.
- ovf  output  1  sticky flag: a push was attempted while full.
- udf  output  1  sticky flag: a tos or pop was attempted while empty.

## Operation
- Storage is `DEPTH` x `WIDTH` registers. Entry i is valid for i < sp, and the top is at index sp-1. Storage contents are not reset.
- Push data is `MtoS ? mem_data : alu_res`, sampled on the same edge as the push.
- Each edge decodes {push, pop, tos} with this priority:
  - push&pop, not empty: replace. `d_out` <= mem[sp-1], then mem[sp-1] <= push data. `sp` is unchanged.
  - push&pop, empty: acts as a push. `udf` <= 1.
  - push only, not full: mem[sp] <= push data, `sp` <= sp+1.
  - push only, full: no write, `sp` unchanged, `ovf` <= 1.
  - pop (tos ignored), not empty: `d_out` <= mem[sp-1], `sp` <= sp-1.
  - pop, empty: `d_out` and `sp` unchanged, `udf` <= 1.
  - tos only, not empty: `d_out` <= mem[sp-1], `sp` unchanged.
  - tos only, empty: `d_out` unchanged, `udf` <= 1.
  - none: all state is held.
- `tos` is ignored whenever `push` or `pop` is asserted.
- `clr_err` clears `ovf`/`udf`. If an error occurs on the same edge as `clr_err`, the error wins and the flag ends up set.
- Error cases never corrupt storage or `sp`. Execution continues; the flags are status only.
- `sp` arithmetic is unsigned SPW-bit and never wraps: it saturates at 0 and DEPTH through the full/empty guards.

## Timing
- Reset (asynchronous, immediate): `sp`=0, `d_out`=0, `ovf`=0, `udf`=0, so `empty`=1 and `full`=0.
- `d_out` is valid the cycle after `tos`/`pop`. This matches the controller: its getTop state feeds the readFromMem address, and its popStage state feeds loadA/loadB one cycle later.
- A pushed word is readable by `tos`/`pop` on the next cycle; there is no bypass within the same edge.
- `sp`, `empty` and `full` reflect an operation in the cycle after its edge.
- Reset asserted mid-sequence abandons everything. On release the stack is empty, and earlier storage contents are unreachable.
- There is no handshake. Every strobe is a single-cycle command and is honoured or flagged on that edge.

## Test plan
- Reset, then push `alu_res`=0x11, 0x22 with MtoS=0, and `mem_data`=0x33 with MtoS=1. Expect `sp`=3. Then tos: `d_out`=0x33, `sp`=3. Then pop, pop, pop: `d_out`=0x33, 0x22, 0x11 on successive cycles, `sp`=0, `empty`=1.
- Push 16 words 0x00..0x0F: `full`=1. A 17th push of 0xFF gives `ovf`=1, `sp`=16. Then pop gives `d_out`=0x0F.
- From empty, pop and tos give `udf`=1 with `d_out` unchanged (0 after reset). Then `clr_err` gives `udf`=0. `clr_err` together with pop on empty leaves `udf`=1.
- Push 0x05, 0x07, then push&pop with `alu_res`=0x0C: `d_out`=0x07, `sp`=2. Next tos gives `d_out`=0x0C.
- Mimic the add sequence (tos, pop, pop, push of 0x12): `d_out` tracks each pop one cycle later, and the final `sp` equals the initial `sp`-1.
- Assert `rst` asynchronously between the two pops of a sequence: `sp`=0, `d_out`=0 and both flags clear immediately, with no clock edge required.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: DEPTH x WIDTH operand stack with registered d_out and sticky overflow/underflow flags
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tos,
    input  logic             pop,
    input  logic             push,
    input  logic             MtoS,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             clr_err,
    output logic [WIDTH-1:0] d_out,
    output logic [SPW-1:0]   sp,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] din;
    logic [SPW-2:0]   push_idx;
    logic [SPW-2:0]   top_idx;
    logic             do_rep;
    logic             do_push;
    logic             do_pop;
    logic             do_rd;
    logic             set_ovf;
    logic             set_udf;

    assign empty    = sp == '0;
    assign full     = sp == SPW'(DEPTH);
    assign din      = MtoS ? mem_data : alu_res;
    assign push_idx = sp[SPW-2:0];
    // sp == DEPTH wraps the low bits to 0, so subtracting one still lands on DEPTH-1
    assign top_idx  = push_idx - (SPW-1)'(1);

    always_comb begin
        do_rep  = push & pop & !empty;
        do_push = push & (!pop | empty) & !full;
        do_pop  = pop & !push & !empty;
        do_rd   = do_rep | do_pop | (tos & !push & !pop & !empty);
        set_ovf = push & !pop & full;
        set_udf = empty & (pop | (tos & !push));
    end

    always_ff @(posedge clk) begin
        if (do_rep)
            mem[top_idx] <= din;
        else if (do_push)
            mem[push_idx] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            d_out <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (do_push)
                sp <= sp + SPW'(1);
            else if (do_pop)
                sp <= sp - SPW'(1);
            if (do_rd)
                d_out <= mem[top_idx];
            ovf <= set_ovf | (ovf & !clr_err);
            udf <= set_udf | (udf & !clr_err);
        end
    end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: table-driven directed vectors plus hand sequences for fill/overflow and async reset
module tb_stack_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tos = 1'b0, pop = 1'b0, push = 1'b0, MtoS = 1'b0, clr_err = 1'b0;
    logic [7:0] mem_data = '0, alu_res = '0;
    logic [7:0] d_out;
    logic [4:0] sp;
    logic       empty, full, ovf, udf;
    int         total = 0;
    int         passed = 0;

    typedef struct {
        logic       push, pop, tos, mtos, clr;
        logic [7:0] mem, alu;
        logic [7:0] d;
        logic [4:0] sp;
        logic       ovf, udf;
    } vec_t;

    vec_t vt[$];

    stack_unit dut (
        .clk(clk), .rst(rst), .tos(tos), .pop(pop), .push(push), .MtoS(MtoS),
        .mem_data(mem_data), .alu_res(alu_res), .clr_err(clr_err),
        .d_out(d_out), .sp(sp), .empty(empty), .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_state(input string tag, input logic [7:0] d, input logic [4:0] s,
                               input logic o, input logic u);
        chk({tag, " d_out"}, 32'(d_out), 32'(d));
        chk({tag, " sp"}, 32'(sp), 32'(s));
        chk({tag, " empty"}, 32'(empty), 32'(s == 0));
        chk({tag, " full"}, 32'(full), 32'(s == 16));
        chk({tag, " ovf"}, 32'(ovf), 32'(o));
        chk({tag, " udf"}, 32'(udf), 32'(u));
    endtask

    task automatic step(input logic pu, input logic po, input logic t, input logic m,
                        input logic c, input logic [7:0] md, input logic [7:0] al);
        push = pu; pop = po; tos = t; MtoS = m; clr_err = c; mem_data = md; alu_res = al;
        @(posedge clk);
        #1;
        push = 0; pop = 0; tos = 0; MtoS = 0; clr_err = 0;
    endtask

    function automatic void add(input logic pu, po, t, m, c, input logic [7:0] md, al, d,
                                input logic [4:0] s, input logic o, u);
        vec_t x;
        x.push = pu; x.pop = po; x.tos = t; x.mtos = m; x.clr = c;
        x.mem = md; x.alu = al; x.d = d; x.sp = s; x.ovf = o; x.udf = u;
        vt.push_back(x);
    endfunction

    initial begin
        //  push pop tos mtos clr  mem    alu    d      sp ovf udf
        add(1, 0, 0, 0, 0, 8'h00, 8'h11, 8'h00, 1, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h22, 8'h00, 2, 0, 0);
        add(1, 0, 0, 1, 0, 8'h33, 8'h44, 8'h00, 3, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h33, 3, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h33, 2, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 1);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 1);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        add(0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 1);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h11, 1, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h07, 8'h11, 2, 0, 0);
        add(1, 1, 0, 0, 0, 8'h00, 8'h0C, 8'h07, 2, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h0C, 2, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'h09, 8'h0C, 3, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h09, 3, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h09, 2, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h0C, 1, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h12, 8'h0C, 2, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h12, 2, 0, 0);

        #12;
        check_state("reset", 8'h00, 0, 0, 0);
        rst = 0;
        @(posedge clk);
        #1;
        foreach (vt[i]) begin
            step(vt[i].push, vt[i].pop, vt[i].tos, vt[i].mtos, vt[i].clr, vt[i].mem, vt[i].alu);
            check_state($sformatf("vec%0d", i), vt[i].d, vt[i].sp, vt[i].ovf, vt[i].udf);
        end

        #2 rst = 1;
        #1 check_state("async_rst1", 8'h00, 0, 0, 0);
        rst = 0;
        step(1, 1, 0, 0, 0, 8'h00, 8'h5A);
        check_state("pushpop_empty", 8'h00, 1, 0, 1);
        step(0, 0, 1, 0, 0, 8'h00, 8'h00);
        check_state("pushpop_empty_tos", 8'h5A, 1, 0, 1);
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        check_state("pushpop_empty_pop", 8'h5A, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0, 8'h00, 8'(i));
            chk($sformatf("fill%0d sp", i), 32'(sp), 32'(i + 1));
        end
        check_state("filled", 8'h5A, 16, 0, 1);
        step(1, 0, 0, 0, 0, 8'h00, 8'hFF);
        check_state("overflow", 8'h5A, 16, 1, 1);
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        check_state("pop_after_ovf", 8'h0F, 15, 1, 1);
        #2 rst = 1;
        #1 check_state("async_rst2", 8'h00, 0, 0, 0);
        rst = 0;
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        check_state("pop_after_rst", 8'h00, 0, 0, 1);
        step(0, 0, 1, 0, 0, 8'h00, 8'h00);
        check_state("tos_after_rst", 8'h00, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
